// File: rtl/chinx_io_pkg.sv
// Shared types and helpers for the switch input-conditioning path.
package chinx_io_pkg;

  typedef enum logic {DB_STABLE, DB_BOUNCE} db_state_t;

  localparam int unsigned IO_WIDTH = 8;

  // Counter must hold 0..cycles; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/chinx_debounce_bit.sv
// Single-input conditioner: 2-flop synchroniser, debounce FSM/counter and
// registered edge pulses one cycle after the debounced level moves.
module chinx_debounce_bit
  import chinx_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter logic        RST_LEVEL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            s;
  logic            stable_q;
  logic            stable_nxt;
  db_state_t       state;
  db_state_t       state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= RST_LEVEL;
      s     <= RST_LEVEL;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DB_STABLE;
      cnt      <= '0;
      stable   <= RST_LEVEL;
      stable_q <= RST_LEVEL;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      stable   <= stable_nxt;
      stable_q <= stable;
      rise     <= stable & ~stable_q;
      fall     <= ~stable & stable_q;
    end
  end

  // cnt counts cycles s has differed from stable; acceptance on the last one.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stable_nxt = stable;
    case (state)
      DB_STABLE: begin
        cnt_nxt = '0;
        if (s != stable) begin
          if (LAST == '0) begin
            stable_nxt = s;
          end else begin
            state_nxt = DB_BOUNCE;
            cnt_nxt   = CW'(1);
          end
        end
      end
      DB_BOUNCE: begin
        if (s == stable) begin
          state_nxt = DB_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          stable_nxt = s;
          state_nxt  = DB_STABLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = DB_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/chinx_gpio_debounce.sv
// Switch conditioning for io0: per-bit debouncers, sticky edge flags with
// pipeline-driven clear, and the zero-extended level byte.
module chinx_gpio_debounce
  import chinx_io_pkg::*;
#(
  parameter int unsigned N_SW            = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter logic        RST_LEVEL       = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SW-1:0]     sw_raw,
  output logic [N_SW-1:0]     sw_stable,
  output logic [N_SW-1:0]     sw_rise,
  output logic [N_SW-1:0]     sw_fall,
  output logic [N_SW-1:0]     edge_flags,
  input  logic                clr_valid,
  input  logic [N_SW-1:0]     clr_mask,
  output logic [IO_WIDTH-1:0] io_byte
);

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    chinx_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_LEVEL       (RST_LEVEL)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i])
    );
  end

  // A fresh edge in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_flags <= '0;
    end else begin
      edge_flags <= (edge_flags & ~({N_SW{clr_valid}} & clr_mask)) | sw_rise | sw_fall;
    end
  end

  assign io_byte = IO_WIDTH'(sw_stable);

endmodule

// File: tb/tb_chinx_gpio_debounce.sv
// Scoreboard bench: two DUTs (4-cycle and 1-cycle debounce) share random
// stimulus; a history-window reference model predicts every cycle.
module tb_chinx_gpio_debounce;

  localparam int unsigned N_SW = 3;
  localparam int unsigned DA   = 4;
  localparam int unsigned DB   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] sw_raw = 3'b111;
  logic       clr_valid = 1'b0;
  logic [2:0] clr_mask = 3'b000;

  logic [2:0] st_a, ri_a, fa_a, fl_a;
  logic [2:0] st_b, ri_b, fa_b, fl_b;
  logic [7:0] io_a, io_b;

  always #5 clk = ~clk;

  chinx_gpio_debounce #(.N_SW(N_SW), .DEBOUNCE_CYCLES(DA), .RST_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_stable(st_a), .sw_rise(ri_a),
    .sw_fall(fa_a), .edge_flags(fl_a), .clr_valid(clr_valid), .clr_mask(clr_mask),
    .io_byte(io_a)
  );

  chinx_gpio_debounce #(.N_SW(N_SW), .DEBOUNCE_CYCLES(DB), .RST_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_stable(st_b), .sw_rise(ri_b),
    .sw_fall(fa_b), .edge_flags(fl_b), .clr_valid(clr_valid), .clr_mask(clr_mask),
    .io_byte(io_b)
  );

  typedef struct packed {
    logic [2:0] st_a, ri_a, fa_a, fl_a;
    logic [2:0] st_b, ri_b, fa_b, fl_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  logic [2:0]  m_s1[2], m_s[2], m_st[2], m_prev[2], m_ri[2], m_fa[2], m_fl[2];
  logic [63:0] m_hist[2][3];
  int          m_nval[2];

  function automatic int unsigned dcyc(input int d);
    return (d == 0) ? DA : DB;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = '0; m_s[d] = '0; m_st[d] = '0; m_prev[d] = '0;
      m_ri[d] = '0; m_fa[d] = '0; m_fl[d] = '0; m_nval[d] = 0;
      for (int b = 0; b < 3; b++) m_hist[d][b] = '0;
    end
  endfunction

  // A level is accepted once the last D synchronised samples all oppose it.
  function automatic void model_edge();
    logic [2:0]  nst;
    logic [63:0] mask;
    for (int d = 0; d < 2; d++) begin
      nst  = m_st[d];
      mask = (64'd1 << dcyc(d)) - 64'd1;
      m_nval[d]++;
      for (int b = 0; b < 3; b++) begin
        m_hist[d][b] = {m_hist[d][b][62:0], m_s[d][b]};
        if (m_nval[d] >= int'(dcyc(d)) &&
            (m_hist[d][b] & mask) == (m_st[d][b] ? 64'd0 : mask))
          nst[b] = ~m_st[d][b];
      end
      m_fl[d]   = (m_fl[d] & ~(clr_valid ? clr_mask : 3'b000)) | m_ri[d] | m_fa[d];
      m_ri[d]   = m_st[d] & ~m_prev[d];
      m_fa[d]   = ~m_st[d] & m_prev[d];
      m_prev[d] = m_st[d];
      m_st[d]   = nst;
      m_s[d]    = m_s1[d];
      m_s1[d]   = sw_raw;
    end
  endfunction

  function automatic exp_t model_pack();
    exp_t e;
    e.st_a = m_st[0]; e.ri_a = m_ri[0]; e.fa_a = m_fa[0]; e.fl_a = m_fl[0];
    e.st_b = m_st[1]; e.ri_b = m_ri[1]; e.fa_b = m_fa[1]; e.fl_b = m_fl[1];
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the prediction.
  task automatic step(input logic r, input logic [2:0] raw, input logic cv, input logic [2:0] cm);
    logic was;
    @(negedge clk);
    was       = rst;
    rst       = r;
    sw_raw    = raw;
    clr_valid = cv;
    clr_mask  = cm;
    if (!r) model_reset();
    else    model_edge();
    exp_q.push_back(model_pack());
    if (!r && was) begin
      #1;
      check("async_rst_stable_a", {5'b0, st_a}, 8'h00);
      check("async_rst_flags_a",  {5'b0, fl_a}, 8'h00);
      check("async_rst_io_a",     io_a,         8'h00);
      check("async_rst_stable_b", {5'b0, st_b}, 8'h00);
    end
  endtask

  // Directed spot check just after the next rising edge.
  task automatic chk_now(input string name, input int sel, input logic [7:0] expv);
    @(posedge clk);
    #2;
    case (sel)
      0:       check(name, {5'b0, st_a}, expv);
      1:       check(name, {5'b0, ri_a}, expv);
      2:       check(name, {5'b0, st_b}, expv);
      3:       check(name, io_a,         expv);
      default: check(name, {5'b0, fl_a}, expv);
    endcase
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stable_a", {5'b0, st_a}, {5'b0, e.st_a});
        check("rise_a",   {5'b0, ri_a}, {5'b0, e.ri_a});
        check("fall_a",   {5'b0, fa_a}, {5'b0, e.fa_a});
        check("flags_a",  {5'b0, fl_a}, {5'b0, e.fl_a});
        check("io_a",     io_a,         {5'b0, e.st_a});
        check("stable_b", {5'b0, st_b}, {5'b0, e.st_b});
        check("rise_b",   {5'b0, ri_b}, {5'b0, e.ri_b});
        check("fall_b",   {5'b0, fa_b}, {5'b0, e.fa_b});
        check("flags_b",  {5'b0, fl_b}, {5'b0, e.fl_b});
        check("io_b",     io_b,         {5'b0, e.st_b});
      end
    end
  end

  initial begin : stim
    logic [2:0] r_raw;
    logic       r_rst;
    model_reset();

    // Reset held with all switches high, then release.
    repeat (3) step(1'b0, 3'b111, 1'b0, 3'b000);
    step(1'b1, 3'b111, 1'b0, 3'b000);
    step(1'b1, 3'b111, 1'b0, 3'b000);
    chk_now("rel_b_edge2", 2, 8'h00);
    step(1'b1, 3'b111, 1'b0, 3'b000);
    chk_now("rel_b_edge3", 2, 8'h07);
    step(1'b1, 3'b111, 1'b0, 3'b000);
    step(1'b1, 3'b111, 1'b0, 3'b000);
    chk_now("rel_a_edge5", 0, 8'h00);
    step(1'b1, 3'b111, 1'b0, 3'b000);
    chk_now("rel_a_edge6", 0, 8'h07);
    step(1'b1, 3'b111, 1'b0, 3'b000);
    chk_now("rel_a_rise", 1, 8'h07);

    // Settle low, clear flags, then a clean step on bit 0.
    repeat (10) step(1'b1, 3'b000, 1'b0, 3'b000);
    step(1'b1, 3'b000, 1'b1, 3'b111);
    repeat (4) step(1'b1, 3'b000, 1'b0, 3'b000);
    repeat (5) step(1'b1, 3'b001, 1'b0, 3'b000);
    chk_now("step_a_edge5", 0, 8'h00);
    step(1'b1, 3'b001, 1'b0, 3'b000);
    chk_now("step_a_io", 3, 8'h01);
    step(1'b1, 3'b001, 1'b0, 3'b000);
    chk_now("step_a_rise", 1, 8'h01);
    step(1'b1, 3'b001, 1'b0, 3'b000);
    chk_now("step_a_flags", 4, 8'h01);

    // Three-cycle glitch on bit 1 must not reach the 4-cycle debouncer.
    repeat (3) step(1'b1, 3'b011, 1'b0, 3'b000);
    repeat (8) step(1'b1, 3'b001, 1'b0, 3'b000);
    chk_now("glitch_a", 0, 8'h01);

    // Reset in the middle of bit 2's bounce window.
    repeat (2) step(1'b1, 3'b101, 1'b0, 3'b000);
    repeat (2) step(1'b0, 3'b101, 1'b0, 3'b000);
    repeat (6) step(1'b1, 3'b101, 1'b0, 3'b000);
    chk_now("rst_bounce_a", 0, 8'h05);
    step(1'b1, 3'b101, 1'b0, 3'b000);
    chk_now("rst_bounce_rise", 1, 8'h05);

    // Random switch activity with clears and rare resets.
    r_raw = 3'b101;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) r_raw[b] = ~r_raw[b];
      r_rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      step(r_rst, r_raw, ($urandom_range(0, 3) == 0), 3'($urandom));
    end
    repeat (3) step(1'b1, r_raw, 1'b0, 3'b000);

    @(posedge clk);
    #3;
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
